anti_noise_i2s_tx: RTL and testbench

//  Serial audio transmitter at the output end of the noise-cancellation path. Accepts one signed
//  16-bit anti-noise sample per ready_in strobe from the FIR stage and serialises it to the DAC
//  as I2S: MSB first, one-bit delay after each LRCLK edge. Mono source: the same sample is sent
//  in the left and right slots. This block mirrors the sample receiver at the input end.

---
 rtl/anti_noise_i2s_pkg.sv | 18 +
 rtl/anti_noise_i2s_tx_bclk_gen.sv | 41 ++++
 rtl/anti_noise_i2s_tx.sv | 120 ++++++++++++
 tb/tb_anti_noise_i2s_tx.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/anti_noise_i2s_pkg.sv
// Shared types and sizing helpers for the anti-noise I2S transmitter.
package anti_noise_i2s_pkg;

   typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} chan_t;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_SLOT_W    = 32;
   localparam int DEF_BCLK_HALF = 16;

   // Bits needed to count 0..n-1; never less than 1 so n=1 still gets a register.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/anti_noise_i2s_tx_bclk_gen.sv
// Bit-clock generator: divides clk_in down to BCLK and flags each BCLK edge one cycle early.
module i2s_bclk_gen
   import anti_noise_i2s_pkg::*;
#(
   parameter int BCLK_HALF = DEF_BCLK_HALF
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic bclk_o,
   output logic fall_stb_o,
   output logic rise_stb_o
);

   localparam int DW = clog2(BCLK_HALF);

   logic [DW-1:0] div_q, div_d;
   logic          bclk_q, bclk_d;
   logic          wrap;

   always_comb begin
      wrap   = (div_q == DW'(BCLK_HALF - 1));
      div_d  = wrap ? '0 : div_q + 1'b1;
      bclk_d = wrap ? ~bclk_q : bclk_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q  <= '0;
         bclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         bclk_q <= bclk_d;
      end
   end

   // Strobes are high in the cycle whose closing edge moves bclk.
   assign fall_stb_o = wrap &  bclk_q;
   assign rise_stb_o = wrap & ~bclk_q;
   assign bclk_o     = bclk_q;

endmodule

// File: rtl/anti_noise_i2s_tx.sv
// I2S transmitter for the anti-noise path: one mono sample per frame, sent in both slots.
module anti_noise_i2s_tx
   import anti_noise_i2s_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int SLOT_W    = DEF_SLOT_W,
   parameter int BCLK_HALF = DEF_BCLK_HALF
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     ready_in,
   input  logic signed [DATA_W-1:0] sample_in,
   output logic                     bclk_out,
   output logic                     lrclk_out,
   output logic                     sdata_out,
   output logic                     underrun_out,
   output logic                     overrun_out
);

   localparam int BW = clog2(SLOT_W);
   localparam int IW = clog2(DATA_W);

   logic fall_stb, rise_stb;

   i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk (
      .clk_i      (clk_in),
      .rst_ni     (rst_in),
      .bclk_o     (bclk_out),
      .fall_stb_o (fall_stb),
      .rise_stb_o (rise_stb)
   );

   assert property (@(posedge clk_in) disable iff (!rst_in) !(fall_stb && rise_stb));

   chan_t                    chan_q, chan_d;
   logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
   logic signed [DATA_W-1:0] shreg_q, hold_q, last_smp_q;
   logic                     hold_valid_q;
   logic                     lrclk_q, lrclk_d;
   logic                     sdata_q, sdata_d;
   logic                     underrun_q, underrun_d;
   logic                     overrun_q, overrun_d;
   logic                     bit_wrap, frame_load;

   // Slot FSM: state register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         chan_q    <= LEFT;
         bit_cnt_q <= '0;
      end else begin
         chan_q    <= chan_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Slot FSM: next state
   always_comb begin
      bit_wrap  = (bit_cnt_q == BW'(SLOT_W - 1));
      chan_d    = chan_q;
      bit_cnt_d = bit_cnt_q;
      if (fall_stb) begin
         bit_cnt_d = bit_wrap ? '0 : bit_cnt_q + 1'b1;
         if (bit_wrap) chan_d = (chan_q == LEFT) ? RIGHT : LEFT;
      end
   end

   // Slot FSM: outputs
   always_comb begin
      frame_load = fall_stb && (chan_q == LEFT) && (bit_cnt_q == '0);
      lrclk_d    = lrclk_q;
      sdata_d    = sdata_q;
      if (fall_stb) begin
         if (bit_cnt_q == '0) begin
            lrclk_d = (chan_q == RIGHT);
            sdata_d = 1'b0;
         end else if (int'(bit_cnt_q) <= DATA_W) begin
            sdata_d = shreg_q[IW'(DATA_W - int'(bit_cnt_q))];
         end else begin
            sdata_d = 1'b0;
         end
      end
      underrun_d = frame_load && !hold_valid_q;
      // A sample arriving on the load cycle refills the freed slot, so it is not an overrun.
      overrun_d  = ready_in && hold_valid_q && !frame_load;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         shreg_q      <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         last_smp_q   <= '0;
         lrclk_q      <= 1'b0;
         sdata_q      <= 1'b0;
         underrun_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
         if (frame_load) begin
            shreg_q <= hold_valid_q ? hold_q : last_smp_q;
            if (hold_valid_q) last_smp_q <= hold_q;
         end
         if (ready_in) begin
            hold_q       <= sample_in;
            hold_valid_q <= 1'b1;
         end else if (frame_load) begin
            hold_valid_q <= 1'b0;
         end
      end
   end

   assign lrclk_out    = lrclk_q;
   assign sdata_out    = sdata_q;
   assign underrun_out = underrun_q;
   assign overrun_out  = overrun_q;

endmodule

// File: tb/tb_anti_noise_i2s_tx.sv
// Directed bench for anti_noise_i2s_tx with a fast bit clock (BCLK_HALF=2).
module tb_anti_noise_i2s_tx;

   logic               clk_in = 1'b0;
   logic               rst_in = 1'b0;
   logic               ready_in = 1'b0;
   logic signed [15:0] sample_in = '0;
   logic               bclk_out, lrclk_out, sdata_out, underrun_out, overrun_out;

   anti_noise_i2s_tx #(.DATA_W(16), .SLOT_W(32), .BCLK_HALF(2)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .ready_in     (ready_in),
      .sample_in    (sample_in),
      .bclk_out     (bclk_out),
      .lrclk_out    (lrclk_out),
      .sdata_out    (sdata_out),
      .underrun_out (underrun_out),
      .overrun_out  (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   int   n_chk = 0, n_err = 0;
   int   un_cnt = 0, ov_cnt = 0, un_bad = 0;
   int   un_snap = 0, ov_snap = 0;
   logic prev_bclk = 1'b0;

   always @(negedge clk_in) begin
      if (underrun_out) begin
         un_cnt++;
         if (lrclk_out) un_bad++;
      end
      if (overrun_out) ov_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic get_rise();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk_in);
         if (bclk_out && !prev_bclk) found = 1'b1;
         prev_bclk = bclk_out;
      end
      if (!found) chk("rise_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_ready(input logic [15:0] s, input int d);
      repeat (d) @(negedge clk_in);
      ready_in  = 1'b1;
      sample_in = s;
      @(negedge clk_in);
      ready_in  = 1'b0;
   endtask

   // Captures one full frame (64 BCLK rises), optionally injecting samples after rise ia / ib.
   task automatic run_frame(input string tag, input int ia, input logic [15:0] sa,
                            input int ib, input logic [15:0] sb, input logic [31:0] exp_slot,
                            input int exp_un, input int exp_ov);
      logic [31:0] sl, sr, ll, lr;
      int          dun, dov;
      sl = '0; sr = '0; ll = '0; lr = '0; dun = 0; dov = 0;
      for (int idx = 0; idx < 64; idx++) begin
         get_rise();
         if (idx < 32) begin
            sl = {sl[30:0], sdata_out};
            ll = {ll[30:0], lrclk_out};
         end else begin
            sr = {sr[30:0], sdata_out};
            lr = {lr[30:0], lrclk_out};
         end
         if (idx == 63) begin
            dun = un_cnt - un_snap;
            dov = ov_cnt - ov_snap;
            un_snap = un_cnt;
            ov_snap = ov_cnt;
         end
         if (idx == ia) pulse_ready(sa, 0);
         if (idx == ib) pulse_ready(sb, 1);
      end
      chk({tag, "_left"},   sl, exp_slot);
      chk({tag, "_right"},  sr, exp_slot);
      chk({tag, "_lr_l"},   ll, 32'h0000_0000);
      chk({tag, "_lr_r"},   lr, 32'hFFFF_FFFF);
      chk({tag, "_under"},  32'(dun), 32'(exp_un));
      chk({tag, "_over"},   32'(dov), 32'(exp_ov));
   endtask

   initial begin
      repeat (6) begin
         @(negedge clk_in);
         ready_in  = 1'($urandom_range(0, 1));
         sample_in = 16'($urandom);
         chk("rst_outs", 32'({bclk_out, lrclk_out, sdata_out, underrun_out, overrun_out}), 32'd0);
      end
      @(negedge clk_in);
      rst_in    = 1'b1;
      ready_in  = 1'b1;
      sample_in = 16'sh8001;
      @(negedge clk_in);
      ready_in = 1'b0;
      chk("bclk_edge1", 32'(bclk_out), 32'd0);
      @(negedge clk_in);
      chk("bclk_edge2", 32'(bclk_out), 32'd1);
      prev_bclk = bclk_out;

      run_frame("f1_8001",  5,  16'h1234, -1, 16'h0000, 32'h4000_8000, 0, 0);
      run_frame("f2_1234",  -1, 16'h0000, -1, 16'h0000, 32'h091A_0000, 0, 0);
      run_frame("f3_under", 10, 16'h0F0F, 40, 16'h7FFF, 32'h091A_0000, 1, 1);
      run_frame("f4_7fff",  20, 16'h5555, 63, 16'h2AAA, 32'h3FFF_8000, 0, 0);
      run_frame("f5_coinc", -1, 16'h0000, -1, 16'h0000, 32'h2AAA_8000, 0, 0);
      run_frame("f6_next",  30, 16'hFFFF, -1, 16'h0000, 32'h1555_0000, 0, 0);

      // Frame carrying 16'hFFFF: stop at RIGHT k=10 where sdata and lrclk are both high.
      for (int idx = 0; idx < 43; idx++) get_rise();
      chk("pre_rst", 32'({lrclk_out, sdata_out}), 32'd3);
      #1 rst_in = 1'b0;
      #1 chk("rst_async", 32'({bclk_out, lrclk_out, sdata_out, underrun_out, overrun_out}), 32'd0);
      repeat (3) @(negedge clk_in);
      un_snap   = un_cnt;
      ov_snap   = ov_cnt;
      rst_in    = 1'b1;
      prev_bclk = 1'b0;
      get_rise();
      run_frame("f8_post_rst", -1, 16'h0000, -1, 16'h0000, 32'h0000_0000, 1, 0);

      chk("under_in_right", 32'(un_bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
